// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmit front end between NREQ byte
// producers, with per-message locking and a lock timeout.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_byte,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        tx_byte,
  output logic              tx_en,
  input  logic              tx_ready,
  output logic [2:0]        grant_id,
  output logic              locked,
  output logic              busy,
  output logic [7:0]        timeout_cnt
);

  localparam int TW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [TW-1:0]   timer;
  logic            last_q;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] ack_vec;
  logic            sel_found;
  logic [2:0]      sel_id;
  logic [7:0]      sel_byte;
  logic            sel_last;

  // Two passes give the round-robin order: indices above the pointer first,
  // then wrap around to the pointer itself.
  always_comb begin
    elig      = '0;
    ack_vec   = '0;
    sel_found = 1'b0;
    sel_id    = '0;
    sel_byte  = '0;
    sel_last  = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      elig[j]    = req_valid[j] && (!locked || (grant_id == 3'(j)));
      ack_vec[j] = (grant_id == 3'(j));
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!sel_found && elig[j] && (j > 32'(ptr))) begin
        sel_found = 1'b1;
        sel_id    = 3'(j);
        sel_byte  = req_byte[8*j +: 8];
        sel_last  = req_last[j];
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!sel_found && elig[j] && (j <= 32'(ptr))) begin
        sel_found = 1'b1;
        sel_id    = 3'(j);
        sel_byte  = req_byte[8*j +: 8];
        sel_last  = req_last[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_en       <= 1'b0;
      tx_byte     <= '0;
      req_ack     <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
      timer       <= '0;
      ptr         <= 3'(NREQ - 1);
      last_q      <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            tx_byte  <= sel_byte;
            last_q   <= sel_last;
            grant_id <= sel_id;
            ptr      <= sel_id;
            tx_en    <= 1'b1;
            busy     <= 1'b1;
            timer    <= '0;
            state    <= DRIVE;
          end else if (locked) begin
            // A found selection takes priority, so reaching here means the owner is idle.
            if (timer == TIMER_LAST) begin
              locked <= 1'b0;
              timer  <= '0;
              if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            timer <= '0;
          end
        end
        DRIVE: begin
          if (!tx_ready) begin
            tx_en   <= 1'b0;
            req_ack <= ack_vec;
            locked  <= ~last_q;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (tx_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          tx_en <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart handshake model and
// per-requester byte queues driven from a single stimulus process.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int LT   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_byte;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ack;
  logic [7:0]        tx_byte;
  logic              tx_en;
  logic              tx_ready;
  logic [2:0]        grant_id;
  logic              locked;
  logic              busy;
  logic [7:0]        timeout_cnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_byte(req_byte),
    .req_last(req_last), .req_ack(req_ack), .tx_byte(tx_byte), .tx_en(tx_en),
    .tx_ready(tx_ready), .grant_id(grant_id), .locked(locked), .busy(busy),
    .timeout_cnt(timeout_cnt)
  );

  int         checks = 0;
  int         errors = 0;
  int         hold_cfg = 0;
  int         u_hold = 0;
  int         u_low = 0;
  logic       u_ready = 1'b1;
  int         multi_ack = 0;
  logic [8:0] pq [NREQ][$];
  int         ack_log [$];
  logic [7:0] byte_log [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_byte[8*i +: 8] = pq[i][0][7:0];
        req_last[i]        = pq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_byte[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: observe after the edge, then update producers and uart model.
  task automatic tick();
    @(posedge clk);
    #1;
    if ($countones(req_ack) > 1) multi_ack++;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ack[i]) begin
        ack_log.push_back(i);
        if (pq[i].size() > 0) void'(pq[i].pop_front());
      end
    end
    if (u_ready) begin
      if (tx_en) begin
        if (u_hold == hold_cfg) begin
          u_ready = 1'b0;
          u_low   = 1;
          u_hold  = 0;
          byte_log.push_back(tx_byte);
        end else begin
          u_hold++;
        end
      end else begin
        u_hold = 0;
      end
    end else begin
      if (u_low <= 1) u_ready = 1'b1;
      else u_low--;
    end
    tx_ready = u_ready;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ack_log.delete();
    byte_log.delete();
  endtask

  task automatic wait_acks(input string tag, input int n, input int limit);
    for (int c = 0; c < limit && ack_log.size() < n; c++) tick();
    check(tag, 64'(ack_log.size()), 64'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"}, 64'(tx_en), 64'd0);
    check({tag, "_tx_byte"}, 64'(tx_byte), 64'h00);
    check({tag, "_req_ack"}, 64'(req_ack), 64'd0);
    check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'd0);
  endtask

  logic [7:0] exp_rr_b [5];
  int         exp_rr_a [5];
  logic [7:0] exp_lk_b [7];
  int         exp_lk_a [7];
  int         ack_seen;

  initial begin
    exp_rr_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_rr_a = '{0, 1, 2, 3, 0};
    exp_lk_b = '{8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h01, 8'h02, 8'h03};
    exp_lk_a = '{1, 1, 1, 0, 0, 0, 0};
    rst_n = 1'b0;
    tx_ready = 1'b1;
    drive();

    // Reset state
    do_reset();
    check_reset_outputs("reset");

    // Single byte from requester 2
    pq[2].push_back({1'b1, 8'h41});
    drive();
    tick();
    check("single_tx_en", 64'(tx_en), 64'd1);
    check("single_tx_byte", 64'(tx_byte), 64'h41);
    check("single_grant", 64'(grant_id), 64'd2);
    check("single_busy", 64'(busy), 64'd1);
    tick();
    check("single_ack", 64'(req_ack), 64'b0100);
    check("single_tx_en_low", 64'(tx_en), 64'd0);
    check("single_locked", 64'(locked), 64'd0);
    tick();
    check("single_ack_one_cycle", 64'(req_ack), 64'd0);
    check("single_idle", 64'(busy), 64'd0);

    // Round-robin with all requesters valid
    do_reset();
    pq[0].push_back({1'b1, 8'h10});
    pq[0].push_back({1'b1, 8'h10});
    pq[1].push_back({1'b1, 8'h11});
    pq[2].push_back({1'b1, 8'h12});
    pq[3].push_back({1'b1, 8'h13});
    drive();
    wait_acks("rr_ack_count", 5, 100);
    check("rr_byte_count", 64'(byte_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < byte_log.size() && i < ack_log.size(); i++) begin
      check($sformatf("rr_byte%0d", i), 64'(byte_log[i]), 64'(exp_rr_b[i]));
      check($sformatf("rr_ack%0d", i), 64'(ack_log[i]), 64'(exp_rr_a[i]));
    end

    // Locked message from requester 1 against a constantly valid requester 0
    ack_log.delete();
    byte_log.delete();
    pq[1].push_back({1'b0, 8'hA0});
    pq[1].push_back({1'b0, 8'hA1});
    pq[1].push_back({1'b1, 8'hA2});
    for (int i = 0; i < 4; i++) pq[0].push_back({1'b1, 8'(i)});
    drive();
    wait_acks("lock_ack_count", 7, 200);
    for (int i = 0; i < 7 && i < byte_log.size() && i < ack_log.size(); i++) begin
      check($sformatf("lock_byte%0d", i), 64'(byte_log[i]), 64'(exp_lk_b[i]));
      check($sformatf("lock_ack%0d", i), 64'(ack_log[i]), 64'(exp_lk_a[i]));
    end
    check("lock_released", 64'(locked), 64'd0);

    // Lock timeout: requester 3 leaves its lock idle
    do_reset();
    pq[3].push_back({1'b0, 8'h33});
    drive();
    wait_acks("to_ack", 1, 50);
    check("to_locked_after_ack", 64'(locked), 64'd1);
    pq[0].push_back({1'b1, 8'h50});
    drive();
    tick();
    for (int i = 0; i < LT - 1; i++) tick();
    check("to_still_locked", 64'(locked), 64'd1);
    check("to_cnt_before", 64'(timeout_cnt), 64'd0);
    tick();
    check("to_unlocked", 64'(locked), 64'd0);
    check("to_cnt_after", 64'(timeout_cnt), 64'd1);
    check("to_no_grant_yet", 64'(tx_en), 64'd0);
    tick();
    check("to_grant_tx_en", 64'(tx_en), 64'd1);
    check("to_grant_byte", 64'(tx_byte), 64'h50);
    check("to_grant_id", 64'(grant_id), 64'd0);
    wait_acks("to_drain", 2, 50);

    // Reset in the middle of DRIVE
    do_reset();
    hold_cfg = 5;
    pq[2].push_back({1'b0, 8'h77});
    drive();
    tick();
    check("rst_mid_tx_en", 64'(tx_en), 64'd1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    hold_cfg = 0;
    wait_acks("rst_mid_resume_ack", 1, 50);
    check("rst_mid_byte_count", 64'(byte_log.size()), 64'd1);
    if (byte_log.size() > 0) check("rst_mid_byte", 64'(byte_log[0]), 64'h77);
    if (ack_log.size() > 0) check("rst_mid_ack_id", 64'(ack_log[0]), 64'd2);
    check("rst_mid_locked", 64'(locked), 64'd1);

    // Back-pressure: tx_ready held high for 20 cycles after tx_en
    do_reset();
    hold_cfg = 20;
    pq[1].push_back({1'b1, 8'h5A});
    drive();
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), {tx_en, tx_byte, 4'(req_ack)}, {1'b1, 8'h5A, 4'b0000});
    end
    tick();
    check("bp_ack", 64'(req_ack), 64'b0010);
    check("bp_tx_en_low", 64'(tx_en), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    ack_seen = ack_log.size();
    check("bp_ack_total", 64'(ack_seen), 64'd1);
    check("bp_idle", 64'(busy), 64'd0);

    check("single_bit_acks", 64'(multi_ack), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart` transmit front end (`tx_byte`/`tx_en`/`tx_ready` handshake) between NREQ independent byte producers.
- Supports message locking: a requester that starts a multi-byte message keeps the port until it marks the last byte.
- A lock timeout prevents a stalled owner from starving the others.
- Sits between the producers (debug logger, command responder, etc.) and the `uart` instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- LOCK_TIMEOUT, 1024, idle cycles an owner may hold a lock without presenting a byte (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  NREQ  requester i has a byte; held with data until req_ack[i]
- req_byte  in  8*NREQ  byte of requester i at [8i+7:8i]
- req_last  in  NREQ  byte is last of message (1 = release lock after it)
- req_ack  out  NREQ  one-cycle pulse: byte of requester i accepted by uart
- tx_byte  out  8  to uart tx_byte
- tx_en  out  1  to uart tx_en
- tx_ready  in  1  from uart tx_ready
- grant_id  out  3  index of current/last granted requester
- locked  out  1  a message lock is held by grant_id
- busy  out  1  state ≠ IDLE
- timeout_cnt  out  8  saturating count of lock timeouts

## Operation
- Reset (rst_n=0 at an edge): state IDLE; tx_en=0, tx_byte=0, req_ack=0, grant_id=0, locked=0, busy=0, timeout_cnt=0, idle timer=0, RR pointer=NREQ-1.
- Downstream handshake: drive tx_en=1 with a stable tx_byte until tx_ready=0, then drop tx_en and wait for tx_ready=1 before the next byte.
- The FSM has three states:
  - IDLE: eligible set = {grant_id} if locked, else all i with req_valid[i]. If the eligible owner is valid, select the first valid index searching from pointer+1 modulo NREQ. On selection: latch req_byte and req_last, set grant_id and pointer to the winner, tx_en<=1, go to DRIVE.
  - DRIVE: tx_en=1 and tx_byte holds the latched byte. When tx_ready=0: tx_en<=0, pulse req_ack[grant_id], locked<=~latched_last, go to RELEASE.
  - RELEASE: tx_en=0. When tx_ready=1: go to IDLE.
- Lock timer:
  - Counts in IDLE while locked and req_valid[grant_id]=0.
  - Clears on any grant or when unlocked.
  - On reaching LOCK_TIMEOUT-1: locked<=0, timer<=0, timeout_cnt increments (saturates at 255), and normal RR arbitration resumes next cycle.
- Requester data is sampled only at selection. Changing req_byte while valid and not yet acked is a protocol violation and is not checked.

## Timing
- Grant latency: req_valid seen in IDLE at edge k gives tx_en=1 and a valid tx_byte after edge k (1 cycle).
- req_ack asserts in the cycle after the edge at which DRIVE samples tx_ready=0. It lasts exactly 1 cycle, and only one bit is ever set.
- Arbiter-imposed minimum is 3 cycles per byte (IDLE, DRIVE, RELEASE). Actual throughput is set by the uart's tx_ready.
- Boundary conditions:
  - Locked owner valid in the same cycle the timer would expire: the grant wins, the timer clears, and there is no timeout.
  - Owner deasserts valid after ack: remain locked, timer starts.
  - Single requester with a continuous stream: granted every byte; RR pointer unchanged in effect.
  - All requesters valid, no locks: grants cycle 0,1,2,3,0… strictly.
  - tx_ready=0 already on entering DRIVE: ack on the first DRIVE cycle.
  - tx_ready stuck high: remain in DRIVE indefinitely. There is no watchdog.
  - Reset mid-DRIVE: tx_en=0 after that edge, no ack, lock dropped. The uart sees tx_en low and completes its own sequence.

## Test plan
- Single byte: req_valid[2]=1, req_byte=0x41, last=1, with the bench uart model. Expect tx_en high 1 cycle later with tx_byte=0x41, one req_ack[2] pulse, locked=0, return to IDLE after tx_ready=1.
- Round-robin: all four valid with last=1 and bytes 0x10..0x13. Expect tx_byte sequence 0x10,0x11,0x12,0x13,0x10, with acks in matching order.
- Lock: requester 1 sends 0xA0,0xA1,0xA2 (last on 0xA2) while requester 0 is constantly valid. Expect all three 0xA* bytes to be consecutive before the first requester-0 byte.
- Lock timeout (LOCK_TIMEOUT=16): requester 3 sends one byte with last=0 then drops valid; requester 0 is valid. Expect locked to fall after 16 idle cycles, timeout_cnt=1, then requester 0 granted.
- Reset mid-DRIVE: drop rst_n for 1 cycle while tx_en=1. Expect all outputs at their reset values next cycle, no req_ack, and normal operation afterwards.
- Back-pressure: the uart model holds tx_ready=1 for 20 cycles after tx_en. Expect tx_en and tx_byte stable throughout, and exactly one ack.
